sample_capture: RTL and testbench

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/sample_capture_pkg.sv | 15 +
 rtl/sample_capture.sv | 116 +++++++++++
 tb/tb_sample_capture.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_capture_pkg.sv
// Shared spectrum-analyzer constants: frame geometry, RAM word width and the
// capture FSM encoding used by sample_capture, bitRevOrder and the FFT stages.
package sample_capture_pkg;

    localparam int N_POINTS = 1024;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } captureState_t;

endpackage

// File: rtl/sample_capture.sv
// Captures one frame of ADC samples into a dual-port RAM, writing samples in
// even/odd pairs so each RAM cycle stores two natural-order points at once.
module sample_capture #(
    parameter int N_POINTS = sample_capture_pkg::N_POINTS,
    parameter int ADDR_W   = sample_capture_pkg::ADDR_W,
    parameter int IN_W     = 12,
    parameter int DATA_W   = sample_capture_pkg::DATA_W,
    parameter int DECIM    = 1
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [IN_W-1:0]   sample_in,
    output logic              write_enableA,
    output logic              write_enableB,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] DoutA,
    output logic [DATA_W-1:0] DoutB,
    output logic              busy,
    output logic              tc
);
    import sample_capture_pkg::*;

    localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_POINTS - 1);

    captureState_t       stateReg, stateNext;
    logic [7:0]          decimCntReg;
    logic [ADDR_W-1:0]   sampleIdxReg;
    logic [DATA_W-1:0]   holdReg;
    logic                lastPendingReg;

    logic                writeEnReg;
    logic [ADDR_W-1:0]   addrAReg, addrBReg;
    logic [DATA_W-1:0]   doutAReg, doutBReg;
    logic                busyReg, tcReg;

    logic [DATA_W-1:0]   sampleExt;
    logic                accept;
    logic                pairWrite;

    assign sampleExt = {{(DATA_W - IN_W){sample_in[IN_W-1]}}, sample_in};

    // Once the final pair has been accepted, further samples are ignored until the frame closes.
    assign accept    = (stateReg == FILL) && sample_valid &&
                       (decimCntReg == 8'd0) && !lastPendingReg;
    assign pairWrite = accept && sampleIdxReg[0];

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = FILL;
            FILL:    if (lastPendingReg) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            stateReg       <= IDLE;
            decimCntReg    <= 8'd0;
            sampleIdxReg   <= '0;
            holdReg        <= '0;
            lastPendingReg <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            lastPendingReg <= pairWrite && (sampleIdxReg == LAST_IDX);
            if (stateReg == IDLE && start) begin
                decimCntReg  <= 8'd0;
                sampleIdxReg <= '0;
            end else if (stateReg == FILL && sample_valid) begin
                decimCntReg <= (decimCntReg == DECIM_LAST) ? 8'd0 : decimCntReg + 8'd1;
                if (accept) begin
                    sampleIdxReg <= sampleIdxReg + 1'b1;
                    if (!sampleIdxReg[0]) holdReg <= sampleExt;
                end
            end
        end
    end

    // Address/data registers only move on a pair write, so they hold between pulses.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            writeEnReg <= 1'b0;
            addrAReg   <= '0;
            addrBReg   <= '0;
            doutAReg   <= '0;
            doutBReg   <= '0;
            busyReg    <= 1'b0;
            tcReg      <= 1'b0;
        end else begin
            writeEnReg <= pairWrite;
            if (pairWrite) begin
                addrAReg <= {sampleIdxReg[ADDR_W-1:1], 1'b0};
                addrBReg <= sampleIdxReg;
                doutAReg <= holdReg;
                doutBReg <= sampleExt;
            end
            busyReg <= (stateNext != IDLE);
            tcReg   <= (stateNext == DONE);
        end
    end

    assign write_enableA = writeEnReg;
    assign write_enableB = writeEnReg;
    assign addrA         = addrAReg;
    assign addrB         = addrBReg;
    assign DoutA         = doutAReg;
    assign DoutB         = doutBReg;
    assign busy          = busyReg;
    assign tc            = tcReg;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a DECIM=1 and a DECIM=4 instance share stimulus and
// are checked every cycle against a count-based frame model.
module tb_sample_capture;

    localparam int N  = 1024;
    localparam int AW = 10;
    localparam int DW = 18;

    logic Clk, reset_n, start, sample_valid;
    logic [11:0] sample_in;

    logic          weA  [2];
    logic          weB  [2];
    logic [AW-1:0] addrA[2];
    logic [AW-1:0] addrB[2];
    logic [DW-1:0] doutA[2];
    logic [DW-1:0] doutB[2];
    logic          busy [2];
    logic          tc   [2];

    sample_capture #(.N_POINTS(N), .ADDR_W(AW), .IN_W(12), .DATA_W(DW), .DECIM(1)) dut0 (
        .Clk(Clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
        .sample_in(sample_in), .write_enableA(weA[0]), .write_enableB(weB[0]),
        .addrA(addrA[0]), .addrB(addrB[0]), .DoutA(doutA[0]), .DoutB(doutB[0]),
        .busy(busy[0]), .tc(tc[0]));

    sample_capture #(.N_POINTS(N), .ADDR_W(AW), .IN_W(12), .DATA_W(DW), .DECIM(4)) dut1 (
        .Clk(Clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
        .sample_in(sample_in), .write_enableA(weA[1]), .write_enableB(weB[1]),
        .addrA(addrA[1]), .addrB(addrB[1]), .DoutA(doutA[1]), .DoutB(doutB[1]),
        .busy(busy[1]), .tc(tc[1]));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checkCnt = 0;
    int passCnt  = 0;
    int failPrints = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Behavioural model: frame tracked as counts of valid cycles and accepted samples.
    bit            mStarted = 0;
    bit            mActive [2];
    int            mFin    [2];
    int            mNValid [2];
    int            mNAcc   [2];
    logic [DW-1:0] mHold   [2];
    logic          eWe     [2];
    logic [AW-1:0] eAddrA  [2];
    logic [AW-1:0] eAddrB  [2];
    logic [DW-1:0] eDA     [2];
    logic [DW-1:0] eDB     [2];
    logic          eBusy   [2];
    logic          eTc     [2];

    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            int dec;
            int sv;
            logic [DW-1:0] v;
            dec = (d == 0) ? 1 : 4;
            sv  = $signed(sample_in);
            v   = sv[DW-1:0];
            eWe[d] = 1'b0;
            eTc[d] = 1'b0;
            if (!reset_n) begin
                mActive[d] = 0; mFin[d] = 0; mHold[d] = '0;
                eAddrA[d] = '0; eAddrB[d] = '0; eDA[d] = '0; eDB[d] = '0;
            end else if (!mActive[d]) begin
                if (start) begin
                    mActive[d] = 1; mFin[d] = 0; mNValid[d] = 0; mNAcc[d] = 0;
                end
            end else if (mFin[d] == 0) begin
                if (sample_valid) begin
                    if (mNValid[d] % dec == 0) begin
                        if (mNAcc[d] % 2 == 0) begin
                            mHold[d] = v;
                        end else begin
                            eWe[d]    = 1'b1;
                            eAddrA[d] = AW'(mNAcc[d] - 1);
                            eAddrB[d] = AW'(mNAcc[d]);
                            eDA[d]    = mHold[d];
                            eDB[d]    = v;
                            if (mNAcc[d] == N - 1) mFin[d] = 1;
                        end
                        mNAcc[d]++;
                    end
                    mNValid[d]++;
                end
            end else if (mFin[d] == 1) begin
                mFin[d] = 2;
                eTc[d]  = 1'b1;
            end else begin
                mActive[d] = 0;
            end
            eBusy[d] = mActive[d];
        end
        mStarted = 1;
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        int            c;
    } pulse_t;

    pulse_t pq0[$];
    pulse_t pq1[$];
    int cyc = 0;
    int pulses[2]      = '{0, 0};
    int tcs[2]         = '{0, 0};
    int tcCyc[2]       = '{-100, -100};
    int tcGap[2]       = '{0, 0};
    int lastPulse[2]   = '{0, 0};
    int busyAfterTc[2] = '{1, 1};

    // Compare and observation process, away from the active edge.
    always @(negedge Clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (mStarted) begin
                checkCnt++;
                if (weA[d] === eWe[d] && weB[d] === eWe[d] && addrA[d] === eAddrA[d] &&
                    addrB[d] === eAddrB[d] && doutA[d] === eDA[d] && doutB[d] === eDB[d] &&
                    busy[d] === eBusy[d] && tc[d] === eTc[d]) begin
                    passCnt++;
                end else if (failPrints < 30) begin
                    failPrints++;
                    $display("FAIL cycle%0d dut%0d: got we=%b%b a=%h b=%h da=%h db=%h busy=%b tc=%b required we=%b a=%h b=%h da=%h db=%h busy=%b tc=%b",
                             cyc, d, weA[d], weB[d], addrA[d], addrB[d], doutA[d], doutB[d], busy[d], tc[d],
                             eWe[d], eAddrA[d], eAddrB[d], eDA[d], eDB[d], eBusy[d], eTc[d]);
                end
            end
            if (tc[d]) begin
                tcs[d]++;
                tcCyc[d] = cyc;
                tcGap[d] = cyc - lastPulse[d];
            end
            if (cyc == tcCyc[d] + 1) busyAfterTc[d] = busy[d];
            if (weA[d]) begin
                pulse_t p;
                p.a = addrA[d]; p.b = addrB[d]; p.da = doutA[d]; p.db = doutB[d]; p.c = cyc;
                pulses[d]++;
                lastPulse[d] = cyc;
                if (d == 0) pq0.push_back(p); else pq1.push_back(p);
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        int bad;
        int n;
        int nValid;
        reset_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample_in = '0;
        repeat (4) step();
        check("reset outputs dut0", {weA[0], weB[0], addrA[0], addrB[0], doutA[0], doutB[0], busy[0], tc[0]}, 0);
        reset_n = 1'b1;
        step();

        // Frame with value = index; start coincides with a valid that must be dropped.
        pq0.delete(); pq1.delete();
        start = 1'b1; sample_valid = 1'b1; sample_in = 12'hABC;
        step();
        start = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            sample_in = 12'(i);
            start = (i == 100);
            step();
        end
        start = 1'b0;
        check("frame1 dut0 pulse count", pq0.size(), 512);
        bad = 0;
        for (int k = 0; k < pq0.size(); k++)
            if (pq0[k].a != AW'(2*k) || pq0[k].b != AW'(2*k+1) ||
                pq0[k].da != DW'(2*k) || pq0[k].db != DW'(2*k+1)) bad++;
        check("frame1 dut0 address/data pattern errors", bad, 0);
        check("frame1 dut0 tc gap after last pulse", tcGap[0], 1);
        check("frame1 dut0 busy after tc", busyAfterTc[0], 0);
        check("frame1 dut0 tc count with valid held in idle", tcs[0], 1);
        check("frame1 dut0 total pulses incl idle", pulses[0], 512);
        check("decim4 pulse count", pq1.size(), 512);
        bad = 0;
        for (int k = 1; k < pq1.size(); k++)
            if (pq1[k].c - pq1[k-1].c != 8) bad++;
        check("decim4 pulse spacing errors", bad, 0);
        check("decim4 tc offset vs decim1 tc", tcCyc[1] - tcCyc[0], 3069);
        check("decim4 last addrB", pq1.size() > 0 ? pq1[pq1.size()-1].b : 0, 1023);
        check("decim4 busy idle", busy[1], 0);

        // Random frame; first two samples are the signed extremes.
        sample_valid = 1'b0;
        step();
        pq0.delete(); pq1.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        nValid = 0;
        n = 0;
        while (!(n > 2 && !busy[0] && !busy[1]) && n < 20000) begin
            sample_valid = ($urandom_range(0, 1) == 1);
            if (sample_valid && nValid == 0) sample_in = 12'h800;
            else if (sample_valid && nValid == 1) sample_in = 12'h7FF;
            else sample_in = 12'($urandom);
            if (sample_valid) nValid++;
            start = busy[0] && busy[1] && ($urandom_range(0, 63) == 0);
            step();
            n++;
        end
        start = 1'b0; sample_valid = 1'b0;
        check("random frame completed within bound", n < 20000, 1);
        check("random dut0 first DoutA", pq0.size() > 0 ? pq0[0].da : 0, 18'h3F800);
        check("random dut0 first DoutB", pq0.size() > 0 ? pq0[0].db : 0, 18'h007FF);
        check("random dut0 pulse count", pq0.size(), 512);
        check("random dut1 pulse count", pq1.size(), 512);

        // Reset after 301 accepted samples, then a full frame.
        step();
        pq0.delete(); pq1.delete();
        start = 1'b1;
        step();
        start = 1'b0; sample_valid = 1'b1;
        for (int i = 0; i < 301; i++) begin
            sample_in = 12'($urandom);
            step();
        end
        check("pre-reset dut0 pulses", pq0.size(), 150);
        reset_n = 1'b0;
        step();
        pq0.delete(); pq1.delete();
        repeat (2) step();
        reset_n = 1'b1;
        sample_valid = 1'b0;
        step();
        check("no write during/after reset", pq0.size() + pq1.size(), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            sample_valid = 1'b1;
            sample_in = 12'(i);
            step();
        end
        sample_valid = 1'b0;
        check("post-reset dut0 pulse count", pq0.size(), 512);
        check("post-reset dut0 first addrA", pq0.size() > 0 ? pq0[0].a : 1, 0);
        bad = 0;
        for (int k = 0; k < pq0.size(); k++)
            if (pq0[k].a != AW'(2*k) || pq0[k].db != DW'(2*k+1)) bad++;
        check("post-reset dut0 pattern errors", bad, 0);
        check("post-reset dut1 pulse count", pq1.size(), 512);
        repeat (3) step();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
